order_route_scheduler: RTL and testbench

ORDER_ROUTE_SCHEDULER -- requirements
Module: order_route_scheduler

---
 rtl/order_route_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_order_route_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/order_route_scheduler.sv
// Round-robin order scheduler with token-bucket rate limiting and a kill switch.
// Optional per-requester grant counters and throttle-cycle counter under ORDER_SCHED_STATS_EN.
module order_route_scheduler #(
   parameter int TOKEN_MAX     = 8,
   parameter int REFILL_CYCLES = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [3:0]   req_valid,
   input  logic [255:0] req_symbol,
   input  logic [127:0] req_qty,
   input  logic [127:0] req_price,
   input  logic [31:0]  req_side,
   output logic [3:0]   req_ready,
   input  logic         halt_req,
   input  logic         resume,
   output logic [63:0]  order_symbol,
   output logic [31:0]  order_qty,
   output logic [31:0]  order_price,
   output logic [7:0]   order_side,
   output logic         order_valid,
   output logic [1:0]   order_src,
   output logic [7:0]   tokens,
   output logic [1:0]   sched_state
`ifdef ORDER_SCHED_STATS_EN
   ,
   output logic [31:0]  grant_count0,
   output logic [31:0]  grant_count1,
   output logic [31:0]  grant_count2,
   output logic [31:0]  grant_count3,
   output logic [31:0]  throttle_cycles
`endif
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_THROTTLE = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   localparam logic [7:0]  TOK_MAX     = TOKEN_MAX[7:0];
   localparam logic [15:0] REFILL_LAST = 16'(REFILL_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  tokens_q, tokens_d;
   logic [15:0] refill_cnt_q, refill_cnt_d;
   logic [1:0]  rr_ptr_q, rr_ptr_d;
   logic        order_valid_q, order_valid_d;
   logic [63:0] order_symbol_q, order_symbol_d;
   logic [31:0] order_qty_q, order_qty_d;
   logic [31:0] order_price_q, order_price_d;
   logic [7:0]  order_side_q, order_side_d;
   logic [1:0]  order_src_q, order_src_d;

   logic        grant_en;
   logic        refill_wrap;
   logic        found;
   logic [1:0]  winner;
   logic [1:0]  idx;

   // Search for the first requester at or after the round-robin pointer.
   always_comb begin
      winner = rr_ptr_q;
      found  = 1'b0;
      idx    = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr_q + 2'(k);
         if (!found && req_valid[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
      grant_en  = !rst && (state_q == ST_RUN) && !halt_req && (tokens_q != 8'd0) && found;
      req_ready = grant_en ? (4'b0001 << winner) : 4'b0000;
   end

   // Tokens: a grant that coincides with a refill cancels out.
   always_comb begin
      refill_wrap  = (refill_cnt_q == REFILL_LAST);
      refill_cnt_d = refill_wrap ? 16'd0 : refill_cnt_q + 16'd1;
      tokens_d     = tokens_q;
      if (grant_en && !refill_wrap)
         tokens_d = tokens_q - 8'd1;
      else if (!grant_en && refill_wrap && (tokens_q != TOK_MAX))
         tokens_d = tokens_q + 8'd1;
      rr_ptr_d = grant_en ? winner + 2'd1 : rr_ptr_q;
   end

   always_comb begin
      state_d = state_q;
      if (halt_req)
         state_d = ST_HALT;
      else begin
         case (state_q)
            ST_RUN:      if (tokens_d == 8'd0) state_d = ST_THROTTLE;
            ST_THROTTLE: if (tokens_q != 8'd0) state_d = ST_RUN;
            ST_HALT:     if (resume) state_d = (tokens_q == 8'd0) ? ST_THROTTLE : ST_RUN;
            default:     state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      order_valid_d  = grant_en;
      order_symbol_d = order_symbol_q;
      order_qty_d    = order_qty_q;
      order_price_d  = order_price_q;
      order_side_d   = order_side_q;
      order_src_d    = order_src_q;
      if (grant_en) begin
         order_symbol_d = req_symbol[64*winner +: 64];
         order_qty_d    = req_qty[32*winner +: 32];
         order_price_d  = req_price[32*winner +: 32];
         order_side_d   = req_side[8*winner +: 8];
         order_src_d    = winner;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_RUN;
         tokens_q       <= TOK_MAX;
         refill_cnt_q   <= 16'd0;
         rr_ptr_q       <= 2'd0;
         order_valid_q  <= 1'b0;
         order_symbol_q <= 64'd0;
         order_qty_q    <= 32'd0;
         order_price_q  <= 32'd0;
         order_side_q   <= 8'd0;
         order_src_q    <= 2'd0;
      end else begin
         state_q        <= state_d;
         tokens_q       <= tokens_d;
         refill_cnt_q   <= refill_cnt_d;
         rr_ptr_q       <= rr_ptr_d;
         order_valid_q  <= order_valid_d;
         order_symbol_q <= order_symbol_d;
         order_qty_q    <= order_qty_d;
         order_price_q  <= order_price_d;
         order_side_q   <= order_side_d;
         order_src_q    <= order_src_d;
      end
   end

   assign order_valid  = order_valid_q;
   assign order_symbol = order_symbol_q;
   assign order_qty    = order_qty_q;
   assign order_price  = order_price_q;
   assign order_side   = order_side_q;
   assign order_src    = order_src_q;
   assign tokens       = tokens_q;
   assign sched_state  = state_q;

`ifdef ORDER_SCHED_STATS_EN
   logic [31:0] grant_cnt_q [4];
   logic [31:0] grant_cnt_d [4];
   logic [31:0] throttle_cnt_q, throttle_cnt_d;

   always_comb begin
      for (int i = 0; i < 4; i++)
         grant_cnt_d[i] = grant_cnt_q[i] + {31'd0, req_ready[i]};
      throttle_cnt_d = throttle_cnt_q + {31'd0, (state_q == ST_THROTTLE)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) grant_cnt_q[i] <= 32'd0;
         throttle_cnt_q <= 32'd0;
      end else begin
         for (int i = 0; i < 4; i++) grant_cnt_q[i] <= grant_cnt_d[i];
         throttle_cnt_q <= throttle_cnt_d;
      end
   end

   assign grant_count0    = grant_cnt_q[0];
   assign grant_count1    = grant_cnt_q[1];
   assign grant_count2    = grant_cnt_q[2];
   assign grant_count3    = grant_cnt_q[3];
   assign throttle_cycles = throttle_cnt_q;
`endif

endmodule

// File: tb/tb_order_route_scheduler.sv
// Directed, table-driven bench for order_route_scheduler (default parameters).
module tb_order_route_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [255:0] req_symbol;
   logic [127:0] req_qty;
   logic [127:0] req_price;
   logic [31:0]  req_side;
   logic [3:0]   req_ready;
   logic         halt_req;
   logic         resume;
   logic [63:0]  order_symbol;
   logic [31:0]  order_qty;
   logic [31:0]  order_price;
   logic [7:0]   order_side;
   logic         order_valid;
   logic [1:0]   order_src;
   logic [7:0]   tokens;
   logic [1:0]   sched_state;
`ifdef ORDER_SCHED_STATS_EN
   logic [31:0]  grant_count0, grant_count1, grant_count2, grant_count3, throttle_cycles;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   order_route_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_symbol   (req_symbol),
      .req_qty      (req_qty),
      .req_price    (req_price),
      .req_side     (req_side),
      .req_ready    (req_ready),
      .halt_req     (halt_req),
      .resume       (resume),
      .order_symbol (order_symbol),
      .order_qty    (order_qty),
      .order_price  (order_price),
      .order_side   (order_side),
      .order_valid  (order_valid),
      .order_src    (order_src),
      .tokens       (tokens),
      .sched_state  (sched_state)
`ifdef ORDER_SCHED_STATS_EN
      ,
      .grant_count0    (grant_count0),
      .grant_count1    (grant_count1),
      .grant_count2    (grant_count2),
      .grant_count3    (grant_count3),
      .throttle_cycles (throttle_cycles)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic        halt;
      logic        resume;
      logic [3:0]  exp_ready;
      logic [7:0]  exp_tokens;
      logic [1:0]  exp_state;
      logic        exp_ov;
      logic [1:0]  exp_src;
      logic [31:0] exp_qty;
   } vec_t;

   vec_t vecs[$];

   function automatic void addVec(input logic [3:0] valid, input logic [3:0] ready,
                                  input logic [7:0] tok, input logic [1:0] st,
                                  input logic ov, input logic [1:0] src, input logic [31:0] qty);
      vec_t v;
      v.valid = valid; v.halt = 1'b0; v.resume = 1'b0;
      v.exp_ready = ready; v.exp_tokens = tok; v.exp_state = st;
      v.exp_ov = ov; v.exp_src = src; v.exp_qty = qty;
      vecs.push_back(v);
   endfunction

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input vec_t v);
      req_valid = v.valid;
      halt_req  = v.halt;
      resume    = v.resume;
      #1;
   endtask

   task automatic checkOutput(input vec_t v, input int row);
      cmp($sformatf("row%0d ready", row), 64'(req_ready), 64'(v.exp_ready));
      cmp($sformatf("row%0d tokens", row), 64'(tokens), 64'(v.exp_tokens));
      cmp($sformatf("row%0d state", row), 64'(sched_state), 64'(v.exp_state));
      cmp($sformatf("row%0d order_valid", row), 64'(order_valid), 64'(v.exp_ov));
      cmp($sformatf("row%0d order_qty", row), 64'(order_qty), 64'(v.exp_qty));
      if (v.exp_ov) begin
         cmp($sformatf("row%0d order_src", row), 64'(order_src), 64'(v.exp_src));
         cmp($sformatf("row%0d order_price", row), 64'(order_price), 64'(32'd2000 + 32'(v.exp_src)));
         cmp($sformatf("row%0d order_symbol", row), 64'(order_symbol), 64'h5359_4D00_0000_0000 | 64'(v.exp_src));
      end
   endtask

   task automatic resetDut();
      rst = 1'b1; req_valid = 4'hF; halt_req = 1'b0; resume = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp("reset ready", 64'(req_ready), 64'h0);
      cmp("reset order_valid", 64'(order_valid), 64'h0);
      cmp("reset tokens", 64'(tokens), 64'd8);
      cmp("reset state", 64'(sched_state), 64'd0);
      cmp("reset order_qty", 64'(order_qty), 64'h0);
      req_valid = 4'h0;
      nextCycle();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         req_symbol[64*i +: 64] = 64'h5359_4D00_0000_0000 | 64'(i);
         req_qty[32*i +: 32]    = 32'd100 + 32'(i);
         req_price[32*i +: 32]  = 32'd2000 + 32'(i);
         req_side[8*i +: 8]     = 8'(i);
      end

      // Round-robin burst drains the bucket, then one order per refill period.
      addVec(4'hF, 4'b0001, 8'd8, 2'd0, 1'b0, 2'd0, 32'd0);
      addVec(4'hF, 4'b0010, 8'd7, 2'd0, 1'b1, 2'd0, 32'd100);
      addVec(4'hF, 4'b0100, 8'd6, 2'd0, 1'b1, 2'd1, 32'd101);
      addVec(4'hF, 4'b1000, 8'd5, 2'd0, 1'b1, 2'd2, 32'd102);
      addVec(4'hF, 4'b0001, 8'd4, 2'd0, 1'b1, 2'd3, 32'd103);
      addVec(4'hF, 4'b0010, 8'd3, 2'd0, 1'b1, 2'd0, 32'd100);
      addVec(4'hF, 4'b0100, 8'd2, 2'd0, 1'b1, 2'd1, 32'd101);
      addVec(4'hF, 4'b1000, 8'd1, 2'd0, 1'b1, 2'd2, 32'd102);
      addVec(4'b0100, 4'b0000, 8'd0, 2'd1, 1'b1, 2'd3, 32'd103);
      for (int c = 9; c <= 15; c++) addVec(4'b0100, 4'b0000, 8'd0, 2'd1, 1'b0, 2'd0, 32'd103);
      addVec(4'b0100, 4'b0000, 8'd1, 2'd1, 1'b0, 2'd0, 32'd103);
      addVec(4'b0100, 4'b0100, 8'd1, 2'd0, 1'b0, 2'd0, 32'd103);
      addVec(4'b0100, 4'b0000, 8'd0, 2'd1, 1'b1, 2'd2, 32'd102);
      for (int c = 19; c <= 31; c++) addVec(4'b0100, 4'b0000, 8'd0, 2'd1, 1'b0, 2'd0, 32'd102);
      addVec(4'b0100, 4'b0000, 8'd1, 2'd1, 1'b0, 2'd0, 32'd102);
      addVec(4'b0100, 4'b0100, 8'd1, 2'd0, 1'b0, 2'd0, 32'd102);
      addVec(4'b0100, 4'b0000, 8'd0, 2'd1, 1'b1, 2'd2, 32'd102);

      resetDut();
      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput(vecs[i], i);
         nextCycle();
      end

      // Refill saturation at full bucket, then grant coinciding with refill wrap.
      resetDut();
      req_valid = 4'h0;
      repeat (16) nextCycle();
      cmp("idle refill saturates", 64'(tokens), 64'd8);
      repeat (10) nextCycle();
      req_valid = 4'b0001;
      repeat (5) nextCycle();
      #1;
      cmp("tokens before wrap grant", 64'(tokens), 64'd3);
      cmp("ready at wrap grant", 64'(req_ready), 64'b0001);
      nextCycle();
      cmp("grant+refill tokens", 64'(tokens), 64'd3);

      // Kill switch wins over a same-cycle request; resume only with halt low.
      halt_req = 1'b1;
      #1;
      cmp("halt blocks ready", 64'(req_ready), 64'h0);
      nextCycle();
      cmp("halt no order", 64'(order_valid), 64'h0);
      cmp("halt state", 64'(sched_state), 64'd2);
      resume = 1'b1;
      nextCycle();
      cmp("resume ignored while halt", 64'(sched_state), 64'd2);
      halt_req = 1'b0;
      #1;
      cmp("halt ready still 0", 64'(req_ready), 64'h0);
      nextCycle();
      resume = 1'b0;
      #1;
      cmp("resumed state", 64'(sched_state), 64'd0);
      cmp("resumed ready", 64'(req_ready), 64'b0001);
      nextCycle();
      halt_req = 1'b1;
      #1;
      cmp("order survives late halt", 64'(order_valid), 64'h1);
      cmp("late halt src", 64'(order_src), 64'd0);
      nextCycle();
      cmp("late halt state", 64'(sched_state), 64'd2);
      cmp("late halt order gone", 64'(order_valid), 64'h0);

      // Asynchronous reset with an order on the output.
      resetDut();
      req_valid = 4'b0011;
      nextCycle();
      cmp("pre-reset order_valid", 64'(order_valid), 64'h1);
      cmp("pre-reset order_qty", 64'(order_qty), 64'd100);
      rst = 1'b1;
      #1;
      cmp("async reset order_valid", 64'(order_valid), 64'h0);
      cmp("async reset tokens", 64'(tokens), 64'd8);
      cmp("async reset ready", 64'(req_ready), 64'h0);
      nextCycle();
      rst = 1'b0;
      #1;
      cmp("post-reset rr_ptr grant", 64'(req_ready), 64'b0001);
      nextCycle();
      cmp("post-reset order src", 64'(order_src), 64'd0);

`ifdef ORDER_SCHED_STATS_EN
      resetDut();
      req_valid = 4'b0010;
      repeat (8) nextCycle();
      req_valid = 4'h0;
      repeat (9) nextCycle();
      cmp("grant_count1", 64'(grant_count1), 64'd8);
      cmp("grant_count0", 64'(grant_count0), 64'd0);
      cmp("throttle_cycles", 64'(throttle_cycles), 64'd9);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
